// File: rtl/lane_stim_chk_if.sv
// Bus between the lane stimulus/checker and its environment: run control,
// parallel lane words towards the mux, the serialised return stream and status.
interface lane_stim_chk_if #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int CW    = 16
);
  logic                      start;
  logic [1:0]                mode;
  logic [LANES-1:0]          valid_mask;
  logic [DW:0]               dut_out;
  logic [LANES*(DW+1)-1:0]   data_out;
  logic                      frame_stb;
  logic                      busy;
  logic                      done;
  logic [CW-1:0]             pass_cnt;
  logic [CW-1:0]             err_cnt;
  logic                      err_pulse;

  modport master (
    input  start, mode, valid_mask, dut_out,
    output data_out, frame_stb, busy, done, pass_cnt, err_cnt, err_pulse
  );

  modport slave (
    output start, mode, valid_mask, dut_out,
    input  data_out, frame_stb, busy, done, pass_cnt, err_cnt, err_pulse
  );
endinterface

// File: rtl/lane_stim_chk.sv
// Lane stimulus generator plus serialised-stream checker for the lane mux chain.
// Generator emits one LANES-word frame every LANES clocks; checker regenerates the sequence.
module lane_stim_chk #(
  parameter int          LANES   = 4,
  parameter int          DW      = 8,
  parameter int          NFRAMES = 8,
  parameter int          LAT     = 2,
  parameter int          CW      = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic            clk4f,
  input  logic            reset_L,
  lane_stim_chk_if.master bus
);

  localparam int WW = DW + 1;
  localparam int NW = NFRAMES * LANES;
  localparam int IW = $clog2(NW + LANES + 1);
  localparam int SW = $clog2(LANES);
  localparam int FW = $clog2(NFRAMES + 1);
  localparam int LW = $clog2(LAT + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < LANES; i++) t = lfsr_step(t);
    return t;
  endfunction

  function automatic logic [DW:0] make_word(input logic [1:0]    md,
                                            input logic          vld,
                                            input logic [IW-1:0] n,
                                            input logic [15:0]   lf);
    logic [DW-1:0] pay;
    int unsigned   bitpos;
    bitpos = 32'(n) % DW;
    case (md)
      2'd0:    pay = DW'(32'(n));
      2'd1:    pay = DW'(1) << bitpos;
      2'd2:    pay = DW'(lf);
      default: pay = '0;
    endcase
    return (md == 2'd3) ? '0 : {vld, pay};
  endfunction

  function automatic logic [LANES*WW-1:0] build_frame(input logic [1:0]       md,
                                                      input logic [LANES-1:0] msk,
                                                      input logic [IW-1:0]    base,
                                                      input logic [15:0]      lf);
    logic [LANES*WW-1:0] f;
    logic [15:0]         s;
    logic [IW-1:0]       n;
    s = lf;
    n = base;
    for (int i = 0; i < LANES; i++) begin
      f[i*WW +: WW] = make_word(md, msk[i], n, s);
      s = lfsr_step(s);
      n = n + IW'(1);
    end
    return f;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [LANES-1:0]    mask_q, mask_d;
  logic [LANES*WW-1:0] data_q, data_d;
  logic                stb_q, stb_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [IW-1:0]       gen_n_q, gen_n_d;
  logic [15:0]         gen_lfsr_q, gen_lfsr_d;
  logic [LW-1:0]       wait_q, wait_d;
  logic [IW-1:0]       chk_n_q, chk_n_d;
  logic [SW-1:0]       chk_lane_q, chk_lane_d;
  logic [15:0]         chk_lfsr_q, chk_lfsr_d;
  logic [CW-1:0]       pass_q, pass_d;
  logic [CW-1:0]       err_q, err_d;
  logic                err_pulse_q, err_pulse_d;
  logic                active;
  logic                cmp_en;
  logic                cmp_ok;
  logic [DW:0]         exp_word;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    data_d      = data_q;
    stb_d       = 1'b0;
    slot_d      = slot_q;
    frame_d     = frame_q;
    gen_n_d     = gen_n_q;
    gen_lfsr_d  = gen_lfsr_q;
    wait_d      = wait_q;
    chk_n_d     = chk_n_q;
    chk_lane_d  = chk_lane_q;
    chk_lfsr_d  = chk_lfsr_q;
    pass_d      = pass_q;
    err_d       = err_q;
    err_pulse_d = 1'b0;

    active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    cmp_en   = active && (wait_q == '0);
    exp_word = make_word(mode_q, mask_q[chk_lane_q], chk_n_q, chk_lfsr_q);
    // Invalid expected words only require the returned valid bit to be clear
    cmp_ok   = exp_word[DW] ? (bus.dut_out == exp_word) : !bus.dut_out[DW];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_RUN;
          mode_d     = bus.mode;
          mask_d     = bus.valid_mask;
          data_d     = build_frame(bus.mode, bus.valid_mask, '0, SEED);
          stb_d      = 1'b1;
          slot_d     = '0;
          frame_d    = '0;
          gen_n_d    = IW'(LANES);
          gen_lfsr_d = lfsr_adv(SEED);
          wait_d     = LW'(LAT);
          chk_n_d    = '0;
          chk_lane_d = '0;
          chk_lfsr_d = SEED;
          pass_d     = '0;
          err_d      = '0;
        end
      end
      S_RUN: begin
        if (slot_q == SW'(LANES - 1)) begin
          slot_d = '0;
          if (frame_q == FW'(NFRAMES - 1)) begin
            data_d  = '0;
            state_d = (LAT == 0) ? S_DONE : S_DRAIN;
          end else begin
            data_d     = build_frame(mode_q, mask_q, gen_n_q, gen_lfsr_q);
            stb_d      = 1'b1;
            frame_d    = frame_q + FW'(1);
            gen_n_d    = gen_n_q + IW'(LANES);
            gen_lfsr_d = lfsr_adv(gen_lfsr_q);
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      S_DRAIN: begin
        if (cmp_en && (chk_n_q == IW'(NW - 1))) state_d = S_DONE;
      end
      default: ;
    endcase

    // Checker trails the generator by LAT cycles, then compares one word per cycle
    if (active) begin
      if (!cmp_en) begin
        wait_d = wait_q - LW'(1);
      end else begin
        chk_n_d     = chk_n_q + IW'(1);
        chk_lfsr_d  = lfsr_step(chk_lfsr_q);
        chk_lane_d  = (chk_lane_q == SW'(LANES - 1)) ? '0 : chk_lane_q + SW'(1);
        err_pulse_d = !cmp_ok;
        if (cmp_ok) begin
          if (pass_q != '1) pass_d = pass_q + CW'(1);
        end else if (err_q != '1) begin
          err_d = err_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk4f) begin
    if (!reset_L) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      stb_q       <= 1'b0;
      slot_q      <= '0;
      frame_q     <= '0;
      gen_n_q     <= '0;
      gen_lfsr_q  <= SEED;
      wait_q      <= '0;
      chk_n_q     <= '0;
      chk_lane_q  <= '0;
      chk_lfsr_q  <= SEED;
      pass_q      <= '0;
      err_q       <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      stb_q       <= stb_d;
      slot_q      <= slot_d;
      frame_q     <= frame_d;
      gen_n_q     <= gen_n_d;
      gen_lfsr_q  <= gen_lfsr_d;
      wait_q      <= wait_d;
      chk_n_q     <= chk_n_d;
      chk_lane_q  <= chk_lane_d;
      chk_lfsr_q  <= chk_lfsr_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.frame_stb = stb_q;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.pass_cnt  = pass_q;
  assign bus.err_cnt   = err_q;
  assign bus.err_pulse = err_pulse_q;

endmodule

// File: tb/tb_lane_stim_chk.sv
// Bench for lane_stim_chk: ideal delayed loopback mux model, reference word
// sequence computed from the pattern rules, randomized runs plus directed corners.
module tb_lane_stim_chk;

  localparam int LA  = 4;
  localparam int DA  = 8;
  localparam int NFA = 4;
  localparam int LTA = 2;
  localparam int NA  = NFA * LA;
  localparam int WA  = DA + 1;

  localparam int LB  = 8;
  localparam int DB  = 16;
  localparam int NFB = 3;
  localparam int NB  = NFB * LB;
  localparam int WB  = DB + 1;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [15:0]      lfsr_seq[NA];
  logic [LA*WA-1:0] first_a;

  lane_stim_chk_if #(.LANES(LA), .DW(DA), .CW(16)) ifa ();
  lane_stim_chk_if #(.LANES(LB), .DW(DB), .CW(16)) ifb ();

  lane_stim_chk #(.LANES(LA), .DW(DA), .NFRAMES(NFA), .LAT(LTA), .CW(16), .SEED(16'hACE1))
    dut_a (.clk4f(clk), .reset_L(rst_n), .bus(ifa));

  lane_stim_chk #(.LANES(LB), .DW(DB), .NFRAMES(NFB), .LAT(0), .CW(16), .SEED(16'hACE1))
    dut_b (.clk4f(clk), .reset_L(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: word n of a run, straight from the pattern definitions
  function automatic logic [DA:0] exp_word_a(input int md, input logic [LA-1:0] mask, input int n);
    logic [DA-1:0] pay;
    case (md)
      0:       pay = DA'(n % (1 << DA));
      1:       pay = DA'(1 << (n % DA));
      2:       pay = lfsr_seq[n][DA-1:0];
      default: return '0;
    endcase
    return {mask[n % LA], pay};
  endfunction

  function automatic logic [LA*WA-1:0] exp_frame_a(input int md, input logic [LA-1:0] mask, input int f);
    logic [LA*WA-1:0] v;
    for (int i = 0; i < LA; i++) v[i*WA +: WA] = exp_word_a(md, mask, f * LA + i);
    return v;
  endfunction

  task automatic run_a(input int md, input logic [LA-1:0] mask, input int inj_n,
                       input int inj_bit, input bit hold);
    logic [WA-1:0]    hist[NA];
    logic [WA-1:0]    w;
    int               ncmp;
    int               nerr;
    int               k;
    bit               inj_hits;
    if (inj_n >= 0) begin
      w        = exp_word_a(md, mask, inj_n);
      inj_hits = w[DA] || (inj_bit == DA);
    end else begin
      inj_hits = 1'b0;
    end
    ifa.start      = 1'b1;
    ifa.mode       = 2'(md);
    ifa.valid_mask = mask;
    @(negedge clk);
    for (int c = 0; c <= NA + LTA + 1; c++) begin
      if (c > 0) @(negedge clk);
      ifa.start = hold && (c < NA + LTA);
      if (c < NA) begin
        check("a_data", 160'(ifa.data_out), 160'(exp_frame_a(md, mask, c / LA)));
        check("a_stb", 160'(ifa.frame_stb), 160'(c % LA == 0));
        hist[c] = ifa.data_out[(c % LA)*WA +: WA];
        if (c == 0) first_a = ifa.data_out;
      end else begin
        check("a_data_idle", 160'(ifa.data_out), 160'(0));
        check("a_stb_idle", 160'(ifa.frame_stb), 160'(0));
      end
      check("a_busy", 160'(ifa.busy), 160'(c < NA + LTA));
      check("a_done", 160'(ifa.done), 160'(c >= NA + LTA));
      ncmp = c - LTA;
      if (ncmp < 0) ncmp = 0;
      if (ncmp > NA) ncmp = NA;
      nerr = (inj_hits && c > inj_n + LTA) ? 1 : 0;
      check("a_err_cnt", 160'(ifa.err_cnt), 160'(nerr));
      check("a_pass_cnt", 160'(ifa.pass_cnt), 160'(ncmp - nerr));
      check("a_err_pulse", 160'(ifa.err_pulse), 160'(inj_hits && c == inj_n + LTA + 1));
      // Loopback: word c-LTA returns now, junk payload where the valid bit is clear
      k = c - LTA;
      if (k >= 0 && k < NA) begin
        w = hist[k];
        if (!w[DA]) w[DA-1:0] = DA'($urandom);
        if (k == inj_n) w[inj_bit] = ~w[inj_bit];
      end else begin
        w = WA'($urandom);
      end
      ifa.dut_out = w;
    end
    check("a_pass_final", 160'(ifa.pass_cnt), 160'(NA - (inj_hits ? 1 : 0)));
  endtask

  task automatic run_b(input logic [LB-1:0] mask);
    logic [WB-1:0] w;
    ifb.start      = 1'b1;
    ifb.mode       = 2'd3;
    ifb.valid_mask = mask;
    @(negedge clk);
    for (int c = 0; c <= NB + 1; c++) begin
      if (c > 0) @(negedge clk);
      ifb.start = 1'b0;
      check("b_data", 160'(ifb.data_out), 160'(0));
      check("b_stb", 160'(ifb.frame_stb), 160'(c < NB && c % LB == 0));
      check("b_busy", 160'(ifb.busy), 160'(c < NB));
      check("b_done", 160'(ifb.done), 160'(c >= NB));
      check("b_pass_cnt", 160'(ifb.pass_cnt), 160'((c < NB) ? c : NB));
      if (c < NB) begin
        w = ifb.data_out[(c % LB)*WB +: WB];
        if (!w[DB]) w[DB-1:0] = DB'($urandom);
      end else begin
        w = WB'($urandom);
      end
      ifb.dut_out = w;
    end
    check("b_err_cnt", 160'(ifb.err_cnt), 160'(0));
  endtask

  task automatic check_a_quiet(input string tag);
    check({tag, "_data"}, 160'(ifa.data_out), 160'(0));
    check({tag, "_stb"}, 160'(ifa.frame_stb), 160'(0));
    check({tag, "_busy"}, 160'(ifa.busy), 160'(0));
    check({tag, "_done"}, 160'(ifa.done), 160'(0));
    check({tag, "_pass"}, 160'(ifa.pass_cnt), 160'(0));
    check({tag, "_err"}, 160'(ifa.err_cnt), 160'(0));
    check({tag, "_pulse"}, 160'(ifa.err_pulse), 160'(0));
  endtask

  initial begin
    int          taps[4];
    logic [15:0] s;
    logic        fb;
    int          md;
    int          inj;
    vectors     = 0;
    miscompares = 0;

    taps = '{16, 14, 13, 11};
    s = 16'hACE1;
    for (int n = 0; n < NA; n++) begin
      lfsr_seq[n] = s;
      fb = 1'b0;
      for (int t = 0; t < 4; t++) fb = fb ^ s[16 - taps[t]];
      s = {fb, s[15:1]};
    end

    rst_n          = 1'b0;
    ifa.start      = 1'b0;
    ifa.mode       = 2'd0;
    ifa.valid_mask = '0;
    ifa.dut_out    = '0;
    ifb.start      = 1'b0;
    ifb.mode       = 2'd0;
    ifb.valid_mask = '0;
    ifb.dut_out    = '0;
    repeat (3) @(negedge clk);
    check_a_quiet("rst");
    check("rst_b_busy", 160'(ifb.busy), 160'(0));
    check("rst_b_data", 160'(ifb.data_out), 160'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_a(0, 4'b1111, -1, 0, 1'b0);
    run_a(0, 4'b0101, -1, 0, 1'b0);
    run_a(0, 4'b1111, 5, 0, 1'b0);

    run_a(2, 4'b1111, -1, 0, 1'b0);
    check("lfsr_word0", 160'(first_a[WA-1:0]), 160'(9'h1E1));
    check("lfsr_word1", 160'(first_a[2*WA-1:WA]), 160'(9'h170));

    run_a(1, 4'b1111, -1, 0, 1'b0);
    check("walk_frame0", 160'(first_a), 160'({9'h108, 9'h104, 9'h102, 9'h101}));

    // Abort in the third RUN cycle
    ifa.start      = 1'b1;
    ifa.mode       = 2'd0;
    ifa.valid_mask = 4'b1111;
    @(negedge clk);
    ifa.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_a_quiet("abort");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_a_quiet("abort_idle");
    run_a(0, 4'b1111, -1, 0, 1'b0);

    run_a(int'($urandom_range(0, 3)), LA'($urandom), -1, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      md  = int'($urandom_range(0, 3));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NA - 1)) : -1;
      run_a(md, LA'($urandom), inj, int'($urandom_range(0, DA)), r[0]);
    end

    run_b(LB'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lane_stim_chk.md
# lane_stim_chk

Parametrised, synthesizable stimulus generator and stream checker for the lane multiplexer chain. It drives LANES parallel lane words, each with a valid flag in the MSB, advancing one frame every LANES clocks. It also checks the serialised stream coming back from the mux under test against an internally regenerated expected sequence, and counts passes and errors. It replaces the fixed, non-synthesizable four-lane stimulus with a configurable pattern source and self-checking.

## Interface
Parameters:
- LANES, 4: number of lanes; must be ≥2.
- DW, 8: payload width; lane word is DW+1 bits, with bit DW = valid. Range 1..16.
- NFRAMES, 8: frames generated per run, ≥1.
- LAT, 2: mux latency in clk4f cycles between lane word n and its appearance on dut_out, ≥0.
- CW, 16: counter width.
- SEED, 16'hACE1: LFSR seed, nonzero.

Ports:
- clk4f  in  1  lane-slot clock; all logic on the rising edge.
- reset_L  in  1  synchronous active-low reset.
- start  in  1  start a run; sampled in IDLE or DONE only.
- mode  in  2  pattern select, latched when start is accepted.
- valid_mask  in  LANES  per-lane valid flag, latched when start is accepted.
- dut_out  in  DW+1  serialised stream from the mux under test.
- data_out  out  LANES*(DW+1)  lane words; lane i occupies bits [i*(DW+1) +: DW+1].
- frame_stb  out  1  high in the cycle data_out presents a new frame.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- pass_cnt  out  CW  compared words that matched.
- err_cnt  out  CW  compared words that mismatched.
- err_pulse  out  1  one-cycle pulse on each mismatch.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN and DONE→RUN on start=1. Entering RUN clears both counters and latches mode and valid_mask. start is ignored in RUN and DRAIN.
- RUN: a slot counter runs 0..LANES-1. Cycle c=0 is the first RUN cycle; at c=0 data_out holds frame 0 and frame_stb=1.
- A new frame loads each time the slot counter wraps, and frame_stb pulses with it.
- After frame NFRAMES-1 has been held for LANES cycles, data_out goes to all zeros. The FSM then enters DRAIN, or DONE directly if LAT=0.
- DRAIN lasts exactly LAT cycles, then the FSM goes to DONE. DONE holds its counters until the next start.
- Word index n = f*LANES + i, for frame f and lane i. The valid bit of lane i is valid_mask[i].
- Payload by mode:
  - 0 = increment: n mod 2^DW.
  - 1 = walking one: 1 << (n mod DW).
  - 2 = LFSR: low DW bits of a 16-bit Fibonacci LFSR with taps 16,14,13,11. Loaded with SEED at run start and stepped once per word, so word n uses the state after n steps (word 0 = SEED).
  - 3 = idle: payload 0 and valid 0 for every lane, regardless of mask.
- Checker: keeps its own copy of the generator sequence. At cycle c = n+LAT, for n in 0..NFRAMES*LANES-1, it compares dut_out against expected word n:
  - if the expected valid bit is 1, dut_out must equal the full DW+1-bit word;
  - if it is 0, only dut_out[DW] must be 0 and the payload is ignored.
- A match increments pass_cnt. A mismatch increments err_cnt and pulses err_pulse. Both counters saturate at 2^CW-1.
- Total compares per run: exactly NFRAMES*LANES.

## Timing
- Reset (reset_L=0 at an edge): state=IDLE; data_out, frame_stb, busy, done, pass_cnt, err_cnt and err_pulse all 0; LFSRs reloaded with SEED.
- Reset during RUN or DRAIN aborts the run immediately. No further compares occur.
- start accepted at edge k: RUN and busy=1 from cycle k+1, with frame 0 on data_out in that cycle.
- Counters and err_pulse are registered. They reflect the compare at cycle c in cycle c+1.
- done rises in the cycle after the last compare. For LAT=0, that is the cycle after the last RUN cycle.
- A start asserted in the same cycle as DONE entry is ignored. A start during DONE restarts the run with the same timing as from IDLE.

## Test plan
- Ideal loopback model (delay LAT=2, 4 lanes serialised in order), mode 0, NFRAMES=4, mask 4'b1111 → pass_cnt=16, err_cnt=0; done 1 cycle after compare 15; frame_stb every 4 cycles.
- Same setup, mask 4'b0101, model forces payload 9'h0AA on invalid slots → pass_cnt=16, err_cnt=0 (payload ignored when valid=0).
- Mode 0, single bit flip injected on word n=5 → err_cnt=1, pass_cnt=15, err_pulse high exactly once, in cycle 5+LAT+1.
- Mode 2 with SEED=16'hACE1, DW=8 → word 0 payload 8'hE1, word 1 = next LFSR step; loopback gives err_cnt=0. Mode 1 → lane payloads 1,2,4,8 in frame 0.
- reset_L=0 in the 3rd RUN cycle → next cycle IDLE, all outputs 0. A subsequent start runs cleanly with pass_cnt=NFRAMES*LANES.
- start pulsed during RUN → ignored, same counts as the baseline. DW=16, LANES=8 build with mode 3 → all data_out 0, pass_cnt=8*NFRAMES.
